// File: rtl/adder_pkg.sv
// Shared types for the pipelined adder: operation encoding and default operand width.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ACC = 2'd2,
    OP_CLR = 2'd3
  } op_e;

endpackage

// File: rtl/adder_pipe_if.sv
// Producer/consumer stream bundle around adder_pipe. The slave modport is the
// arithmetic block's view; master is the producer/consumer side.
interface adder_pipe_if #(
  parameter int WIDTH = adder_pkg::DEFAULT_WIDTH
);
  import adder_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_e              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   q;
  logic [WIDTH:0]   acc;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, q, acc
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, q, acc
  );

endinterface

// File: rtl/adder_pipe_stage.sv
// One valid+data delay register; loads when en is high, holds otherwise.
// Synchronous active-high reset clears both valid and data.
module adder_pipe_stage #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_vld,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  output logic [DW-1:0] out_dat
);

  logic          vld_d, vld_q;
  logic [DW-1:0] dat_d, dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (en) begin
      vld_d = in_vld;
      dat_d = in_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q;
  assign out_dat = dat_q;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/sub/accumulate unit: result computed in stage 1, then LATENCY-1 delay stages.
// Whole pipe stalls when the output is held (out_valid && !out_ready); order is preserved.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  adder_pipe_if.slave io
);

  localparam int RW = WIDTH + 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("adder_pipe: WIDTH must be >= 2");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("adder_pipe: LATENCY must be >= 1");
  end

  logic          advance;
  logic          accept;
  logic [RW-1:0] res;
  logic [RW-1:0] acc_d, acc_q;
  logic          s1_vld_d, s1_vld_q;
  logic [RW-1:0] s1_dat_d, s1_dat_q;
  logic          vld_chain [LATENCY];
  logic [RW-1:0] dat_chain [LATENCY];

  assign advance     = !io.out_valid || io.out_ready;
  assign io.in_ready = advance && !rst;
  assign accept      = io.in_valid && io.in_ready;

  // CLR yields res=0, so ACC and CLR share the same accumulator write path.
  always_comb begin
    res   = '0;
    acc_d = acc_q;
    case (io.op)
      OP_ADD:  res = {1'b0, io.a} + {1'b0, io.b};
      OP_SUB:  res = {1'b0, io.a} - {1'b0, io.b};
      OP_ACC:  res = acc_q + {1'b0, io.a};
      default: res = '0;
    endcase
    if (accept && (io.op == OP_ACC || io.op == OP_CLR)) begin
      acc_d = res;
    end
  end

  always_comb begin
    s1_vld_d = advance ? accept : s1_vld_q;
    s1_dat_d = accept ? res : s1_dat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
      acc_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
      acc_q    <= acc_d;
    end
  end

  assign vld_chain[0] = s1_vld_q;
  assign dat_chain[0] = s1_dat_q;

  for (genvar i = 1; i < LATENCY; i++) begin : g_delay
    adder_pipe_stage #(.DW(RW)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (advance),
      .in_vld  (vld_chain[i-1]),
      .in_dat  (dat_chain[i-1]),
      .out_vld (vld_chain[i]),
      .out_dat (dat_chain[i])
    );
  end

  assign io.out_valid = vld_chain[LATENCY-1];
  assign io.q         = dat_chain[LATENCY-1];
  assign io.acc       = acc_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe (WIDTH=8, LATENCY=2) with a queue-based reference model.
`timescale 1ps/1ps
module tb_adder_pipe;
  import adder_pkg::*;

  localparam int W = 8;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  adder_pipe_if #(.WIDTH(W)) io ();
  adder_pipe #(.WIDTH(W), .LATENCY(L)) dut (.clk(clk), .rst(rst), .io(io));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: queue of results owed to the consumer, plus accumulator value.
  logic [W:0] exp_q [$];
  logic [W:0] got   [$];
  int         out_cyc [$];
  logic [W:0] m_acc = '0;
  logic [W:0] prev_q = '0;
  logic       prev_stall = 1'b0;
  logic       prev_rst = 1'b0;
  int         cyc = 0;

  always @(negedge clk) begin
    logic [W:0] r;
    cyc++;
    if (prev_rst) begin
      check("rst_out_valid", io.out_valid, 0);
      check("rst_q", io.q, 0);
    end
    check("acc", io.acc, m_acc);
    check("in_ready", io.in_ready, !rst && (!io.out_valid || io.out_ready));
    if (prev_stall) begin
      check("hold_valid", io.out_valid, 1);
      check("hold_q", io.q, prev_q);
    end
    if (io.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", io.out_valid, 0);
      end else if (io.out_ready) begin
        check("q", io.q, exp_q.pop_front());
        got.push_back(io.q);
        out_cyc.push_back(cyc);
      end
    end
    prev_stall = io.out_valid && !io.out_ready;
    prev_q     = io.q;
    if (io.in_valid && io.in_ready) begin
      case (io.op)
        OP_ADD:  r = {1'b0, io.a} + {1'b0, io.b};
        OP_SUB:  r = {1'b0, io.a} - {1'b0, io.b};
        OP_ACC:  begin m_acc = m_acc + {1'b0, io.a}; r = m_acc; end
        default: begin m_acc = '0; r = '0; end
      endcase
      exp_q.push_back(r);
    end
    if (rst) begin
      exp_q.delete();
      m_acc      = '0;
      prev_stall = 1'b0;
    end
    prev_rst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input op_e op);
    logic ok;
    io.in_valid = 1'b1;
    io.a        = a;
    io.b        = b;
    io.op       = op;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = io.in_ready;
      tick();
      if (ok) return;
    end
    check("send_timeout", io.in_ready, 1);
  endtask

  task automatic idle();
    io.in_valid = 1'b0;
  endtask

  logic [W-1:0] ra [16];
  logic [W-1:0] rb [16];
  op_e          rop [16];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    io.in_valid  = 1'b0;
    io.a         = '0;
    io.b         = '0;
    io.op        = OP_ADD;
    io.out_ready = 1'b1;
    repeat (3) tick();
    check("reset_in_ready", io.in_ready, 0);
    check("reset_acc", io.acc, 0);
    rst = 1'b0;
    tick();

    // Basic add with exact latency and single-cycle output pulse
    send(8'hAA, 8'hBB, OP_ADD);
    idle();
    check("add_not_early", io.out_valid, 0);
    tick();
    check("add_valid", io.out_valid, 1);
    check("add_q", io.q, 9'h165);
    tick();
    check("add_one_cycle", io.out_valid, 0);

    // Subtract, with and without borrow
    got.delete();
    send(8'h10, 8'h20, OP_SUB);
    send(8'hFF, 8'h01, OP_SUB);
    idle();
    repeat (3) tick();
    check("sub_count", got.size(), 2);
    check("sub_borrow", got[0], 9'h1F0);
    check("sub_plain", got[1], 9'h0FE);

    // Accumulate with wrap, ADD interleaved
    got.delete();
    send(8'h00, 8'h00, OP_CLR);
    send(8'hFF, 8'h55, OP_ACC);
    send(8'h01, 8'h02, OP_ADD);
    send(8'hFF, 8'h00, OP_ACC);
    send(8'hFF, 8'h00, OP_ACC);
    idle();
    repeat (3) tick();
    check("acc_count", got.size(), 5);
    check("acc_clr", got[0], 9'h000);
    check("acc_1", got[1], 9'h0FF);
    check("acc_add", got[2], 9'h003);
    check("acc_2", got[3], 9'h1FE);
    check("acc_wrap", got[4], 9'h0FD);
    check("acc_final", io.acc, 9'h0FD);

    // Backpressure: consumer stalls while four adds are offered
    got.delete();
    io.out_ready = 1'b0;
    fork
      begin
        send(8'h01, 8'h02, OP_ADD);
        send(8'h10, 8'h20, OP_ADD);
        send(8'hFF, 8'hFF, OP_ADD);
        send(8'h80, 8'h80, OP_ADD);
        idle();
      end
      begin
        repeat (3) tick();
        check("bp_in_ready", io.in_ready, 0);
        check("bp_valid", io.out_valid, 1);
        check("bp_q", io.q, 9'h003);
        repeat (2) tick();
        io.out_ready = 1'b1;
      end
    join
    repeat (4) tick();
    check("bp_count", got.size(), 4);
    check("bp_0", got[0], 9'h003);
    check("bp_1", got[1], 9'h030);
    check("bp_2", got[2], 9'h1FE);
    check("bp_3", got[3], 9'h100);

    // Throughput: 16 back-to-back transactions
    for (int i = 0; i < 16; i++) begin
      ra[i]  = W'($urandom_range(0, 255));
      rb[i]  = W'($urandom_range(0, 255));
      rop[i] = op_e'($urandom_range(0, 3));
    end
    got.delete();
    out_cyc.delete();
    for (int i = 0; i < 16; i++) send(ra[i], rb[i], rop[i]);
    idle();
    repeat (4) tick();
    check("tp_count", got.size(), 16);
    if (out_cyc.size() == 16) check("tp_consecutive", out_cyc[15] - out_cyc[0], 15);

    // Reset mid-flight drops in-flight work and the accumulator
    got.delete();
    io.out_ready = 1'b0;
    send(8'h05, 8'h00, OP_ACC);
    send(8'h01, 8'h01, OP_ADD);
    idle();
    rst = 1'b1;
    check("rst_in_ready_now", io.in_ready, 0);
    tick();
    check("mid_rst_valid", io.out_valid, 0);
    check("mid_rst_q", io.q, 0);
    check("mid_rst_acc", io.acc, 0);
    check("mid_rst_in_ready", io.in_ready, 0);
    rst = 1'b0;
    io.out_ready = 1'b1;
    repeat (3) tick();
    check("no_stale", got.size(), 0);
    send(8'h07, 8'h03, OP_SUB);
    idle();
    repeat (3) tick();
    check("post_rst_count", got.size(), 1);
    check("post_rst_q", got[0], 9'h004);

    check("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
